muxpga_cfg_loader: RTL and testbench
====================================

# muxpga_cfg_loader

Configuration transmitter for the muxpga fabric. It holds a 24-nibble bitstream written by a host and shifts it into the fabric's configuration chain using `cmd=0` beats. It then recirculates the chain once to read every nibble back and verify it. After loading, it can hand the fabric over to run mode (`cmd=1`) with a host-supplied input nibble. It sits between the host/test controller and the fabric's `io_in`/`io_out` pins, and shares the fabric clock.

## Interface
Parameters:
- `NIBBLES`, 24: configuration chain length; must equal the fabric's `cell_cfg` depth.
- `AW`, 5: buffer address width, ceil(log2(NIBBLES)).

Ports:
- `clk`  in  1  single clock, shared with the fabric `io_in[0]`.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  host buffer write strobe.
- `wr_addr`  in  AW  buffer index 0..NIBBLES-1; entry i is the value destined for `cell_cfg[i]`.
- `wr_data`  in  4  nibble to store.
- `start`  in  1  begin a load/verify sequence.
- `run_en`  in  1  while idle and loaded, put the fabric in run mode.
- `run_nibble`  in  4  data nibble for the fabric in run mode.
- `fab_out`  in  8  fabric `io_out`.
- `fab_reset`  out  1  to fabric `io_in[1]`, active-high.
- `fab_nibble`  out  4  to fabric `io_in[5:2]`.
- `fab_cmd`  out  2  to fabric `io_in[7:6]`.
- `busy`  out  1  a sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence ends.
- `loaded`  out  1  the fabric holds a verified bitstream.
- `verify_err`  out  1  sticky flag: last readback mismatched; cleared by `start`.

## Operation
- Buffer: NIBBLES x 4 registers.
  - Write only when not busy.
  - Writes with `wr_addr >= NIBBLES` are ignored.
  - Writes while busy are dropped.
- States: IDLE -> FRST -> SHIFT -> VERIFY -> FIN -> IDLE.
- IDLE:
  - `fab_reset=0`, `fab_nibble=run_nibble`.
  - `fab_cmd = (run_en && loaded) ? 2'b01 : 2'b10` (hold).
  - `start` moves to FRST and clears `loaded` and `verify_err`.
- FRST (1 cycle): `fab_reset=1`, `fab_cmd=2'b10`. This clears the fabric chain and cell flops.
- SHIFT (NIBBLES cycles, beat k=0..NIBBLES-1):
  - `fab_cmd=0`, `fab_nibble=buf[NIBBLES-1-k]`.
  - Highest index is sent first, so after the last beat `cell_cfg[i]=buf[i]`.
- VERIFY (NIBBLES cycles, beat j=0..NIBBLES-1):
  - `fab_cmd=0`, `fab_nibble=buf[NIBBLES-1-j]`, so the chain is rewritten with identical content.
  - On each beat, compare `fab_out[7:4]` (current `cell_cfg[NIBBLES-1]`) with `buf[NIBBLES-1-j]`.
  - Any mismatch sets `verify_err`.
- FIN (1 cycle):
  - `fab_cmd=2'b10`; `done=1`.
  - `loaded = ~verify_err` (including a mismatch on the final beat); return to IDLE.
- `start` outside IDLE is ignored.
- `run_en` is ignored unless in IDLE with `loaded=1`.
- Beat counter runs 0..NIBBLES-1 and is reused by SHIFT and VERIFY; it clears on every state entry.

## Timing
- All outputs are registered. The value computed for state S appears the cycle the FSM is in S, and the fabric samples it at the end of that cycle.
- `start` sampled high in IDLE at edge t gives:
  - FRST during cycle t+1.
  - SHIFT during t+2..t+NIBBLES+1.
  - VERIFY during t+NIBBLES+2..t+2·NIBBLES+1.
  - FIN/`done` at t+2·NIBBLES+2.
  - For NIBBLES=24, total latency is 50 cycles from `start` to `done`.
- `busy` is high from FRST through FIN inclusive.
- The VERIFY compare uses `fab_out` in the same cycle the beat is presented. `fab_out[7:4]` is combinational from the fabric's registered `cell_cfg[NIBBLES-1]`, so no extra pipeline stage is needed.
- Reset values (`reset=0` at an edge):
  - State IDLE; buffer contents are don't-care.
  - `fab_reset=1`, `fab_cmd=2'b10`, `fab_nibble=0`.
  - `busy=0`, `done=0`, `loaded=0`, `verify_err=0`.
- Reset mid-sequence aborts immediately; the sequence does not resume.
- After reset deasserts, the first cycle drives `fab_reset=0` from IDLE.
- `start` and `wr_en` in the same IDLE cycle: the write completes, and the new value is used by SHIFT.

## Test plan
- Load `buf[i]=i mod 16` with a real fabric attached, then `start` ->
  - `done` exactly 50 cycles later.
  - `loaded=1`, `verify_err=0`.
  - Fabric `cell_cfg[i]=i mod 16` for all i.
- Same load, but force `fab_out[7:4]=4'hF` on VERIFY beat 5 -> `verify_err=1`, `loaded=0`; `done` still pulses at cycle 50.
- With `loaded=1`, set `run_en=1` and `run_nibble=4'hA` -> next cycle `fab_cmd=01`, `fab_nibble=A`. Drop `run_en` -> `fab_cmd=10`.
- Pulse `start` at cycle 10 of SHIFT, plus `wr_en` with `wr_addr=3` and `wr_data=7` -> both ignored. Sequence completes in 50 cycles, and `buf[3]` is unchanged.
- Assert `reset` low during VERIFY beat 12 -> next cycle `busy=0`, `loaded=0`, `fab_reset=1`. A subsequent `start` runs a full 50-cycle sequence.
- Write with `wr_addr=24`, then load -> buffer entries 0..23 are unaffected and verify passes.

Source files
------------

// File: rtl/muxpga_cfg_loader.sv
// Configuration loader for the muxpga fabric: buffers a host bitstream, shifts it
// into the fabric chain, reads it back once to verify, then hands over to run mode.
module muxpga_cfg_loader #(
  parameter int unsigned NIBBLES = 24,
  parameter int unsigned AW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic          start,
  input  logic          run_en,
  input  logic [3:0]    run_nibble,
  input  logic [7:0]    fab_out,
  output logic          fab_reset,
  output logic [3:0]    fab_nibble,
  output logic [1:0]    fab_cmd,
  output logic          busy,
  output logic          done,
  output logic          loaded,
  output logic          verify_err
);

  localparam logic [1:0]    CMD_SHIFT = 2'b00;
  localparam logic [1:0]    CMD_RUN   = 2'b01;
  localparam logic [1:0]    CMD_HOLD  = 2'b10;
  localparam logic [AW-1:0] LAST      = AW'(NIBBLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FRST,
    SHIFT,
    VERIFY,
    FIN
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [3:0]    cfg_buf [NIBBLES];

  logic          last_beat;
  logic          mismatch;
  logic [3:0]    expect_nib;
  logic          err_n;
  logic          loaded_n;
  logic          fab_reset_n;
  logic [3:0]    fab_nibble_n;
  logic [1:0]    fab_cmd_n;
  logic          busy_n;
  logic          done_n;
  logic          unused_fab_out;

  assign unused_fab_out = ^fab_out[3:0];

  // Readback: the chain tail is combinational from the fabric's registered cell_cfg.
  assign last_beat  = (cnt == LAST);
  assign expect_nib = cfg_buf[LAST - cnt];
  assign mismatch   = (state == VERIFY) && (fab_out[7:4] != expect_nib);

  // Host buffer writes, accepted only while idle and in range.
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE) && (32'(wr_addr) < NIBBLES)) begin
      cfg_buf[wr_addr] <= wr_data;
    end
  end

  // Next state, next beat and next registered outputs (computed for the next state).
  always_comb begin
    state_n      = state;
    cnt_n        = '0;
    err_n        = verify_err | mismatch;
    loaded_n     = loaded;
    fab_reset_n  = 1'b0;
    fab_cmd_n    = CMD_HOLD;
    fab_nibble_n = '0;
    busy_n       = 1'b1;
    done_n       = 1'b0;

    case (state)
      IDLE:    if (start) state_n = FRST;
      FRST:    state_n = SHIFT;
      SHIFT:   if (last_beat) state_n = VERIFY;
      VERIFY:  if (last_beat) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if ((state_n == state) && ((state == SHIFT) || (state == VERIFY))) begin
      cnt_n = cnt + AW'(1);
    end

    if ((state == IDLE) && start) begin
      err_n    = 1'b0;
      loaded_n = 1'b0;
    end
    if (state_n == FIN) begin
      loaded_n = ~err_n;
    end

    case (state_n)
      IDLE: begin
        busy_n       = 1'b0;
        fab_nibble_n = run_nibble;
        if (run_en && loaded_n) fab_cmd_n = CMD_RUN;
      end
      FRST:          fab_reset_n = 1'b1;
      SHIFT, VERIFY: begin
        fab_cmd_n    = CMD_SHIFT;
        fab_nibble_n = cfg_buf[LAST - cnt_n];
      end
      FIN:           done_n = 1'b1;
      default:       busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      fab_reset  <= 1'b1;
      fab_cmd    <= CMD_HOLD;
      fab_nibble <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      loaded     <= 1'b0;
      verify_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      fab_reset  <= fab_reset_n;
      fab_cmd    <= fab_cmd_n;
      fab_nibble <= fab_nibble_n;
      busy       <= busy_n;
      done       <= done_n;
      loaded     <= loaded_n;
      verify_err <= err_n;
    end
  end

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Bench for muxpga_cfg_loader with a behavioural fabric chain and a scoreboard of
// expected sequence outcomes (latency, loaded, verify_err).
module tb_muxpga_cfg_loader;

  localparam int N  = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_data = '0;
  logic          start = 1'b0;
  logic          run_en = 1'b0;
  logic [3:0]    run_nibble = '0;
  logic [7:0]    fab_out;
  logic          fab_reset;
  logic [3:0]    fab_nibble;
  logic [1:0]    fab_cmd;
  logic          busy, done, loaded, verify_err;

  typedef struct {
    int lat;
    bit ld;
    bit err;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model [N];
  logic [3:0] chain [N];
  int         cyc = 0;
  bit         force_arm = 1'b0;
  int         force_cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  muxpga_cfg_loader #(.NIBBLES(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .run_en(run_en), .run_nibble(run_nibble), .fab_out(fab_out),
    .fab_reset(fab_reset), .fab_nibble(fab_nibble), .fab_cmd(fab_cmd),
    .busy(busy), .done(done), .loaded(loaded), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  // Fabric configuration chain: cmd=0 shifts a nibble in at cell 0, tail is cell N-1.
  assign fab_out = (force_arm && cyc == force_cyc) ? 8'hF0 : {chain[N-1], 4'h0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fab_reset) begin
      for (int i = 0; i < N; i++) chain[i] <= 4'h0;
    end else if (fab_cmd == 2'b00) begin
      chain[0] <= fab_nibble;
      for (int i = 1; i < N; i++) chain[i] <= chain[i-1];
    end
  end

  task automatic write_nib(input int addr, input logic [3:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    if (addr < N) model[addr] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Drives start (optionally with a mid-SHIFT start/write and a forced readback
  // error) and waits for done; latency is counted as in "start at edge t, done in cycle t+L".
  task automatic run_seq(input bit force_err, input bit inject, output int lat,
                         output bit ld, output bit err, output bit timeout,
                         output bit fr_busy, output bit fr_loaded, output bit fr_err);
    int t0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    t0 = cyc;
    fr_busy = busy; fr_loaded = loaded; fr_err = verify_err;
    force_arm = force_err;
    force_cyc = t0 + N + 6;
    timeout = 1'b1; lat = 0; ld = 1'b0; err = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (inject && cyc == t0 + 11) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = AW'(3); wr_data = 4'h7;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = cyc - t0 + 1; ld = loaded; err = verify_err; timeout = 1'b0;
        break;
      end
    end
    force_arm = 1'b0; start = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 7;
    if (fab_reset !== 1'b1) begin n_fail++; $display("FAIL rst_fab_reset: got %0b expected 1", fab_reset); end
    if (fab_cmd !== 2'b10) begin n_fail++; $display("FAIL rst_fab_cmd: got %0b expected 10", fab_cmd); end
    if (fab_nibble !== 4'h0) begin n_fail++; $display("FAIL rst_fab_nibble: got %0h expected 0", fab_nibble); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b expected 0", done); end
    if (loaded !== 1'b0) begin n_fail++; $display("FAIL rst_loaded: got %0b expected 0", loaded); end
    if (verify_err !== 1'b0) begin n_fail++; $display("FAIL rst_verify_err: got %0b expected 0", verify_err); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp += 2;
    if (fab_reset !== 1'b0) begin n_fail++; $display("FAIL rel_fab_reset: got %0b expected 0", fab_reset); end
    if (fab_cmd !== 2'b10) begin n_fail++; $display("FAIL rel_fab_cmd: got %0b expected 10", fab_cmd); end
  endtask

  task automatic test_load;
    int lat; bit ld, err, to, fb, fl, fe; exp_t e;
    for (int i = 0; i < N; i++) write_nib(i, 4'(i % 16));
    sb.push_back('{2*N+2, 1'b1, 1'b0});
    run_seq(1'b0, 1'b0, lat, ld, err, to, fb, fl, fe);
    e = sb.pop_front();
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL load_timeout: no done within 200 cycles"); end
    else begin
      n_cmp += 4;
      if (fb !== 1'b1) begin n_fail++; $display("FAIL load_frst_busy: got %0b expected 1", fb); end
      if (lat != e.lat) begin n_fail++; $display("FAIL load_latency: got %0d expected %0d", lat, e.lat); end
      if (ld !== e.ld) begin n_fail++; $display("FAIL load_loaded: got %0b expected %0b", ld, e.ld); end
      if (err !== e.err) begin n_fail++; $display("FAIL load_verify_err: got %0b expected %0b", err, e.err); end
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (chain[i] !== model[i]) begin n_fail++; $display("FAIL load_cell_cfg[%0d]: got %0h expected %0h", i, chain[i], model[i]); end
      end
    end
  endtask

  task automatic test_run;
    run_en = 1'b1; run_nibble = 4'hA;
    @(posedge clk); #1;
    n_cmp += 2;
    if (fab_cmd !== 2'b01) begin n_fail++; $display("FAIL run_cmd: got %0b expected 01", fab_cmd); end
    if (fab_nibble !== 4'hA) begin n_fail++; $display("FAIL run_nibble: got %0h expected a", fab_nibble); end
    run_en = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (fab_cmd !== 2'b10) begin n_fail++; $display("FAIL run_drop_cmd: got %0b expected 10", fab_cmd); end
  endtask

  task automatic test_busy_ignore;
    int lat; bit ld, err, to, fb, fl, fe; exp_t e;
    sb.push_back('{2*N+2, 1'b1, 1'b0});
    run_seq(1'b0, 1'b1, lat, ld, err, to, fb, fl, fe);
    e = sb.pop_front();
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL busy_timeout: no done within 200 cycles"); end
    else begin
      n_cmp += 6;
      if (fl !== 1'b0) begin n_fail++; $display("FAIL busy_start_clears_loaded: got %0b expected 0", fl); end
      if (lat != e.lat) begin n_fail++; $display("FAIL busy_latency: got %0d expected %0d", lat, e.lat); end
      if (ld !== e.ld) begin n_fail++; $display("FAIL busy_loaded: got %0b expected %0b", ld, e.ld); end
      if (err !== e.err) begin n_fail++; $display("FAIL busy_verify_err: got %0b expected %0b", err, e.err); end
      if (chain[3] !== model[3]) begin n_fail++; $display("FAIL busy_buf3: got %0h expected %0h", chain[3], model[3]); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_restart: got %0b expected 0", busy); end
    end
  endtask

  task automatic test_verify_err;
    int lat; bit ld, err, to, fb, fl, fe; exp_t e;
    sb.push_back('{2*N+2, 1'b0, 1'b1});
    run_seq(1'b1, 1'b0, lat, ld, err, to, fb, fl, fe);
    e = sb.pop_front();
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL verr_timeout: no done within 200 cycles"); end
    else begin
      n_cmp += 3;
      if (lat != e.lat) begin n_fail++; $display("FAIL verr_latency: got %0d expected %0d", lat, e.lat); end
      if (ld !== e.ld) begin n_fail++; $display("FAIL verr_loaded: got %0b expected %0b", ld, e.ld); end
      if (err !== e.err) begin n_fail++; $display("FAIL verr_verify_err: got %0b expected %0b", err, e.err); end
    end
    run_en = 1'b1; run_nibble = 4'h5;
    @(posedge clk); #1;
    n_cmp++;
    if (fab_cmd !== 2'b10) begin n_fail++; $display("FAIL verr_run_ignored: got %0b expected 10", fab_cmd); end
    run_en = 1'b0;
  endtask

  task automatic test_wr_oob;
    int lat; bit ld, err, to, fb, fl, fe; exp_t e;
    write_nib(24, 4'hE);
    write_nib(31, 4'hD);
    sb.push_back('{2*N+2, 1'b1, 1'b0});
    run_seq(1'b0, 1'b0, lat, ld, err, to, fb, fl, fe);
    e = sb.pop_front();
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL oob_timeout: no done within 200 cycles"); end
    else begin
      n_cmp += 4;
      if (fe !== 1'b0) begin n_fail++; $display("FAIL oob_start_clears_err: got %0b expected 0", fe); end
      if (lat != e.lat) begin n_fail++; $display("FAIL oob_latency: got %0d expected %0d", lat, e.lat); end
      if (ld !== e.ld) begin n_fail++; $display("FAIL oob_loaded: got %0b expected %0b", ld, e.ld); end
      if (err !== e.err) begin n_fail++; $display("FAIL oob_verify_err: got %0b expected %0b", err, e.err); end
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (chain[i] !== model[i]) begin n_fail++; $display("FAIL oob_cell_cfg[%0d]: got %0h expected %0h", i, chain[i], model[i]); end
      end
    end
  endtask

  task automatic test_mid_reset;
    int lat, t0; bit ld, err, to, fb, fl, fe; exp_t e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 100 && cyc != t0 + 37; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %0b expected 0", busy); end
    if (loaded !== 1'b0) begin n_fail++; $display("FAIL mrst_loaded: got %0b expected 0", loaded); end
    if (fab_reset !== 1'b1) begin n_fail++; $display("FAIL mrst_fab_reset: got %0b expected 1", fab_reset); end
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) write_nib(i, 4'((i * 5 + 1) % 16));
    sb.push_back('{2*N+2, 1'b1, 1'b0});
    run_seq(1'b0, 1'b0, lat, ld, err, to, fb, fl, fe);
    e = sb.pop_front();
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL mrst_timeout: no done within 200 cycles"); end
    else begin
      n_cmp += 3;
      if (lat != e.lat) begin n_fail++; $display("FAIL mrst_latency: got %0d expected %0d", lat, e.lat); end
      if (ld !== e.ld) begin n_fail++; $display("FAIL mrst_loaded_after: got %0b expected %0b", ld, e.ld); end
      if (err !== e.err) begin n_fail++; $display("FAIL mrst_verify_err: got %0b expected %0b", err, e.err); end
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (chain[i] !== model[i]) begin n_fail++; $display("FAIL mrst_cell_cfg[%0d]: got %0h expected %0h", i, chain[i], model[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit ld, err, to, fb, fl, fe; exp_t e;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        wr_en = 1'b1; wr_addr = AW'(0); wr_data = 4'h9; model[0] = 4'h9;
      end
      sb.push_back('{2*N+2, 1'b1, 1'b0});
      run_seq(1'b0, 1'b0, lat, ld, err, to, fb, fl, fe);
      e = sb.pop_front();
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL b2b_timeout[%0d]: no done within 200 cycles", r); end
      else begin
        n_cmp += 3;
        if (lat != e.lat) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", r, lat, e.lat); end
        if (ld !== e.ld) begin n_fail++; $display("FAIL b2b_loaded[%0d]: got %0b expected %0b", r, ld, e.ld); end
        if (chain[0] !== model[0]) begin n_fail++; $display("FAIL b2b_cell0[%0d]: got %0h expected %0h", r, chain[0], model[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_busy_ignore();
    test_verify_err();
    test_wr_oob();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
